// File: rtl/prog_seq_pkg.sv
// Shared types and constants for the program sequencer and its helpers.
// The optional run timeout is controlled by the PROG_SEQ_TIMEOUT_EN macro in program_sequencer.
package prog_seq_pkg;

    localparam int DEFAULT_NUM_PROGS = 3;

    typedef logic [1:0] prog_sel_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LAUNCH   = 3'd1,
        RUN      = 3'd2,
        REPORT   = 3'd3,
        FINISHED = 3'd4
    } state_e;

endpackage

// File: rtl/edge_detect_rise.sv
// Registered rising-edge detector for a level signal (Halt, Branch, ...).
// o_rise is high in the cycle where i_sig is 1 and was 0 on the previous edge.
module edge_detect_rise (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_rise
);

    logic r_sig_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sig_q <= 1'b0;
        end else begin
            r_sig_q <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_sig_q;

endmodule

// File: rtl/program_sequencer.sv
// Run controller: launches each program image in turn, times it until Halt rises and reports the count.
// Define PROG_SEQ_TIMEOUT_EN to add the TIMEOUT parameter and the TimedOut output.
module program_sequencer
    import prog_seq_pkg::*;
#(
    parameter int NUM_PROGS    = DEFAULT_NUM_PROGS,
    parameter int START_CYCLES = 2,
    parameter int CNT_W        = 16,
    parameter int SEL_W        = 2
`ifdef PROG_SEQ_TIMEOUT_EN
    ,
    parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(16'hFFF0)
`endif
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Req,
    input  logic             Halt,
    output logic             Start,
    output logic [SEL_W-1:0] ProgSel,
    output logic [CNT_W-1:0] CycleCount,
    output logic             Done,
    output logic             AllDone,
    output state_e           o_dbg_state
`ifdef PROG_SEQ_TIMEOUT_EN
    ,
    output logic             TimedOut
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(NUM_PROGS);
    localparam logic [3:0]       START_LOAD = 4'(START_CYCLES);

    state_e           r_state;
    state_e           w_next;
    logic [3:0]       r_start_cnt;
    logic [CNT_W-1:0] r_run_cnt;
    logic [CNT_W-1:0] r_cycle_count;
    logic [SEL_W-1:0] r_prog_sel;
    logic             r_all_done;
    logic             w_halt_rise;
    logic             w_timeout;
`ifdef PROG_SEQ_TIMEOUT_EN
    logic             r_timed_out;
`endif

    edge_detect_rise u_halt_edge (
        .i_clk  (CLK),
        .i_rst  (Reset),
        .i_sig  (Halt),
        .o_rise (w_halt_rise)
    );

`ifdef PROG_SEQ_TIMEOUT_EN
    assign w_timeout = (r_run_cnt == TIMEOUT);
`else
    assign w_timeout = 1'b0;
`endif

    // Halt is only looked at in RUN: during LAUNCH the core may still show the previous Halt.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (Req && !r_all_done) w_next = LAUNCH;
            LAUNCH:   if (r_start_cnt <= 4'd1) w_next = RUN;
            RUN:      if (w_halt_rise || w_timeout) w_next = REPORT;
            REPORT:   w_next = (r_prog_sel == LAST_SEL) ? FINISHED : IDLE;
            FINISHED: w_next = FINISHED;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state       <= IDLE;
            r_start_cnt   <= 4'd0;
            r_run_cnt     <= '0;
            r_cycle_count <= '0;
            r_prog_sel    <= SEL_W'(1);
            r_all_done    <= 1'b0;
`ifdef PROG_SEQ_TIMEOUT_EN
            r_timed_out   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_next == LAUNCH) begin
                        r_run_cnt   <= '0;
                        r_start_cnt <= START_LOAD;
                    end
                end
                LAUNCH: begin
                    if (r_start_cnt != 4'd0) r_start_cnt <= r_start_cnt - 4'd1;
                end
                RUN: begin
                    // The halt_rise cycle is not counted; the counter saturates rather than wraps.
                    if (w_next == REPORT) begin
                        r_cycle_count <= r_run_cnt;
`ifdef PROG_SEQ_TIMEOUT_EN
                        r_timed_out   <= ~w_halt_rise;
`endif
                    end else if (r_run_cnt != CNT_MAX) begin
                        r_run_cnt <= r_run_cnt + CNT_W'(1);
                    end
                end
                REPORT: begin
                    if (r_prog_sel == LAST_SEL) r_all_done <= 1'b1;
                    else                        r_prog_sel <= r_prog_sel + SEL_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign Start       = (r_state == LAUNCH);
    assign Done        = (r_state == REPORT);
    assign ProgSel     = r_prog_sel;
    assign CycleCount  = r_cycle_count;
    assign AllDone     = r_all_done;
    assign o_dbg_state = r_state;
`ifdef PROG_SEQ_TIMEOUT_EN
    assign TimedOut    = r_timed_out;
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: a 16-bit and a 4-bit counter instance run in lockstep.
// Expected counts come from scanning each generated Halt waveform for its first rising edge.
module tb_program_sequencer;
    import prog_seq_pkg::*;

    // ---------------- clock / reset / DUTs ----------------
    logic clk = 1'b0;
    logic rst, req, halt;

    logic        start_a, done_a, alldone_a;
    logic [1:0]  sel_a;
    logic [15:0] cnt_a;
    state_e      st_a;
    logic        start_b, done_b, alldone_b;
    logic [1:0]  sel_b;
    logic [3:0]  cnt_b;
    state_e      st_b;
`ifdef PROG_SEQ_TIMEOUT_EN
    logic        tmo_a, tmo_b;
`endif

    always #5 clk = ~clk;

    program_sequencer #(.NUM_PROGS(3), .START_CYCLES(2), .CNT_W(16), .SEL_W(2)) dut_a (
        .CLK(clk), .Reset(rst), .Req(req), .Halt(halt),
        .Start(start_a), .ProgSel(sel_a), .CycleCount(cnt_a),
        .Done(done_a), .AllDone(alldone_a), .o_dbg_state(st_a)
`ifdef PROG_SEQ_TIMEOUT_EN
        , .TimedOut(tmo_a)
`endif
    );

    program_sequencer #(.NUM_PROGS(3), .START_CYCLES(2), .CNT_W(4), .SEL_W(2)) dut_b (
        .CLK(clk), .Reset(rst), .Req(req), .Halt(halt),
        .Start(start_b), .ProgSel(sel_b), .CycleCount(cnt_b),
        .Done(done_b), .AllDone(alldone_b), .o_dbg_state(st_b)
`ifdef PROG_SEQ_TIMEOUT_EN
        , .TimedOut(tmo_b)
`endif
    );

    // ---------------- scoreboard ----------------
    int total  = 0;
    int passed = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: count = index of the first RUN cycle where Halt is 1 after being 0.
    function automatic int ref_count(input bit prev, input bit lv[$]);
        bit p;
        p = prev;
        foreach (lv[i]) begin
            if (lv[i] && !p) return i;
            p = lv[i];
        end
        return -1;
    endfunction

    function automatic logic [31:0] sat(input logic [31:0] v, input int w);
        logic [31:0] m;
        m = (32'd1 << w) - 32'd1;
        return (v > m) ? m : v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"},   32'(st_a),      32'(IDLE));
        chk({tag, "_sel"},     32'(sel_a),     32'd1);
        chk({tag, "_start"},   32'(start_a),   32'd0);
        chk({tag, "_done"},    32'(done_a),    32'd0);
        chk({tag, "_alldone"}, 32'(alldone_a), 32'd0);
        chk({tag, "_count"},   32'(cnt_a),     32'd0);
        chk({tag, "_count4"},  32'(cnt_b),     32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        req = 1'b0;
        tick();
        check_reset_values(tag);
        rst = 1'b0;
        halt = 1'b0;
        tick();
    endtask

    task automatic run_prog(input bit pre_high, input int k, input int l,
                            input bit hold_req, input int prog, input bit last);
        bit lv[$];
        int exp_cnt, n_start, early;
        logic [31:0] e;
        for (int i = 0; i < k; i++) lv.push_back(1'b1);
        for (int i = 0; i < l; i++) lv.push_back(1'b0);
        lv.push_back(1'b1);
        exp_cnt = ref_count(pre_high, lv);
        exp_q.push_back(32'(exp_cnt));

        chk("idle_before_launch", 32'(st_a), 32'(IDLE));
        req  = 1'b1;
        halt = pre_high;
        tick();
        if (!hold_req) req = 1'b0;
        n_start = 0;
        for (int c = 0; c < 20 && start_a; c++) begin
            n_start++;
            tick();
        end
        chk("start_len", 32'(n_start), 32'd2);
        chk("sel_in_run", 32'(sel_a), 32'(prog));

        early = 0;
        for (int i = 0; i < lv.size(); i++) begin
            halt = lv[i];
            tick();
            if (i < lv.size() - 1 && (done_a || st_a != RUN)) early++;
        end
        chk("no_early_report", 32'(early), 32'd0);
        chk("done", 32'(done_a), 32'd1);
        chk("done4", 32'(done_b), 32'd1);
        e = exp_q.pop_front();
        chk("count16", 32'(cnt_a), sat(e, 16));
        chk("count4", 32'(cnt_b), sat(e, 4));
        chk("sel_report", 32'(sel_a), 32'(prog));

        tick();
        chk("done_pulse", 32'(done_a), 32'd0);
        chk("alldone", 32'(alldone_a), 32'(last));
        chk("alldone4", 32'(alldone_b), 32'(last));
        chk("sel_next", 32'(sel_a), last ? 32'(prog) : 32'(prog + 1));
        chk("state_after", 32'(st_a), last ? 32'(FINISHED) : 32'(IDLE));
    endtask

    task automatic check_finished;
        int n;
        n = 0;
        req = 1'b1;
        repeat (6) begin
            tick();
            if (start_a || start_b || done_a) n++;
        end
        chk("no_start_after_all", 32'(n), 32'd0);
        chk("finished_state", 32'(st_a), 32'(FINISHED));
        chk("finished_sel", 32'(sel_a), 32'd3);
        chk("finished_alldone", 32'(alldone_a), 32'd1);
        req = 1'b0;
    endtask

    task automatic random_prog(input int prog, input bit last);
        bit ph;
        int k, l;
        ph = 1'($urandom_range(0, 1));
        k  = ph ? $urandom_range(0, 4) : 0;
        l  = $urandom_range(ph ? 1 : 0, 24);
        run_prog(ph, k, l, 1'($urandom_range(0, 1)), prog, last);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int n;
        rst  = 1'b1;
        req  = 1'b0;
        halt = 1'b0;
        tick();
        tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        // Single Req pulse, 10 counted cycles; stale Halt case; saturation of the 4-bit copy.
        run_prog(1'b0, 0, 10, 1'b0, 1, 1'b0);
        run_prog(1'b1, 3, 2, 1'b1, 2, 1'b0);
        run_prog(1'b0, 0, 20, 1'b1, 3, 1'b1);
        check_finished();

        // Back-to-back runs with Req held high.
        do_reset("reset2");
        run_prog(1'b0, 0, 5, 1'b1, 1, 1'b0);
        run_prog(1'b0, 0, 7, 1'b1, 2, 1'b0);
        run_prog(1'b0, 0, 9, 1'b1, 3, 1'b1);
        check_finished();

        // Reset in the middle of program 2's RUN phase.
        do_reset("reset3");
        run_prog(1'b0, 0, 3, 1'b0, 1, 1'b0);
        req = 1'b1;
        tick();
        req = 1'b0;
        n = 0;
        while (start_a && n < 20) begin
            n++;
            tick();
        end
        chk("mid_start_len", 32'(n), 32'd2);
        repeat (4) tick();
        chk("mid_in_run", 32'(st_a), 32'(RUN));
        chk("mid_sel", 32'(sel_a), 32'd2);
        rst = 1'b1;
        tick();
        check_reset_values("mid_reset");
        rst = 1'b0;
        tick();
        run_prog(1'b0, 0, 0, 1'b0, 1, 1'b0);

        // Randomized full sessions.
        for (int s = 0; s < 3; s++) begin
            do_reset("reset_rand");
            random_prog(1, 1'b0);
            random_prog(2, 1'b0);
            random_prog(3, 1'b1);
            check_finished();
        end

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
